// File: rtl/spi_transfer_arbiter_pkg.sv
// Shared types for the SPI transfer arbiter slice.
//   state_t         : burst controller states
//   DEFAULT_DIV_BIT : fill bit for the reset divider (all-ones = slowest SPI clock)
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT_TX,
    ST_START,
    ST_WAIT_DONE,
    ST_RELEASE
  } state_t;

  localparam logic DEFAULT_DIV_BIT = 1'b1;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : index holding highest priority this round
//   any_o : at least one request present
//   gnt_o : one-hot winner
//   idx_o : binary index of the winner
module spi_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan N positions starting at the pointer; the first request seen wins.
  always_comb begin
    any_o = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(ptr_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_transfer_arbiter.sv
// Round-robin sharing of one spi_master core between NUM_REQUESTERS clients.
// A granted client owns the core for a burst of words; its CPOL/CPHA/divider
// are latched at grant and held on the core for the whole burst.
//   i_clock, i_reset_n            : clock, synchronous active-low reset
//   i_req / i_req_len / i_req_cfg : per-client burst request and configuration
//   i_tx_data/i_tx_valid/o_tx_ready : per-client tx word handshake
//   o_grant                       : one-hot owner
//   o_rx_data/o_rx_valid          : received word, pulsed to the owner
//   o_burst_done/o_burst_error    : end-of-burst pulses
//   o_spi_* / i_spi_*             : spi_master core interface
module spi_transfer_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS          = 4,
  parameter int unsigned SPI_DATA_WIDTH          = 8,
  parameter int unsigned SPI_CLOCK_DIVIDER_WIDTH = 5,
  parameter int unsigned LEN_WIDTH               = 4,
  parameter int unsigned TIMEOUT_WIDTH           = 16
) (
  input  logic                                                    i_clock,
  input  logic                                                    i_reset_n,
  input  logic [NUM_REQUESTERS-1:0]                               i_req,
  input  logic [NUM_REQUESTERS-1:0][LEN_WIDTH-1:0]                i_req_len,
  input  logic [NUM_REQUESTERS-1:0]                               i_req_cpol,
  input  logic [NUM_REQUESTERS-1:0]                               i_req_cpha,
  input  logic [NUM_REQUESTERS-1:0][SPI_CLOCK_DIVIDER_WIDTH-1:0]  i_req_div,
  input  logic [NUM_REQUESTERS-1:0][SPI_DATA_WIDTH-1:0]           i_tx_data,
  input  logic [NUM_REQUESTERS-1:0]                               i_tx_valid,
  output logic [NUM_REQUESTERS-1:0]                               o_tx_ready,
  output logic [NUM_REQUESTERS-1:0]                               o_grant,
  output logic [SPI_DATA_WIDTH-1:0]                               o_rx_data,
  output logic [NUM_REQUESTERS-1:0]                               o_rx_valid,
  output logic [NUM_REQUESTERS-1:0]                               o_burst_done,
  output logic [NUM_REQUESTERS-1:0]                               o_burst_error,
  output logic                                                    o_spi_enable,
  output logic                                                    o_spi_clock_polarity,
  output logic                                                    o_spi_clock_phase,
  output logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]                      o_spi_clock_divider,
  output logic [SPI_DATA_WIDTH-1:0]                               o_spi_data,
  input  logic [SPI_DATA_WIDTH-1:0]                               i_spi_data,
  input  logic                                                    i_spi_done,
  input  logic                                                    i_spi_busy
);

  localparam int unsigned IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUESTERS - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  // Watchdog fires on the cycle it would reach all-ones.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  state_t                              state_q;
  logic [IDX_W-1:0]                    ptr_q;
  logic [IDX_W-1:0]                    owner_q;
  logic [NUM_REQUESTERS-1:0]           grant_q;
  logic [LEN_WIDTH-1:0]                cnt_q;
  logic [TIMEOUT_WIDTH-1:0]            wd_q;
  logic                                cpol_q;
  logic                                cpha_q;
  logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]  div_q;
  logic [SPI_DATA_WIDTH-1:0]           spi_data_q;
  logic [SPI_DATA_WIDTH-1:0]           rx_data_q;
  logic [NUM_REQUESTERS-1:0]           rx_valid_q;
  logic [NUM_REQUESTERS-1:0]           done_q;
  logic [NUM_REQUESTERS-1:0]           err_q;
  logic                                en_q;

  logic                                arb_any;
  logic [NUM_REQUESTERS-1:0]           arb_gnt;
  logic [IDX_W-1:0]                    arb_idx;

  spi_rr_arbiter #(
    .N     (NUM_REQUESTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .any_o (arb_any),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      wd_q       <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= {SPI_CLOCK_DIVIDER_WIDTH{DEFAULT_DIV_BIT}};
      spi_data_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= '0;
      done_q     <= '0;
      err_q      <= '0;
      en_q       <= 1'b0;
    end else begin
      rx_valid_q <= '0;
      done_q     <= '0;
      err_q      <= '0;
      en_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q <= arb_gnt;
            owner_q <= arb_idx;
            cpol_q  <= i_req_cpol[arb_idx];
            cpha_q  <= i_req_cpha[arb_idx];
            div_q   <= i_req_div[arb_idx];
            cnt_q   <= (i_req_len[arb_idx] == '0) ? LEN_ONE : i_req_len[arb_idx];
            state_q <= ST_SETTLE;
          end
        end
        // Config changed on entry; one cycle here gives the core that cycle.
        ST_SETTLE: begin
          if (!i_spi_busy) state_q <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_valid[owner_q]) begin
            spi_data_q <= i_tx_data[owner_q];
            state_q    <= ST_START;
          end else if (!i_req[owner_q]) begin
            err_q   <= grant_q;
            state_q <= ST_RELEASE;
          end
        end
        ST_START: begin
          en_q    <= 1'b1;
          wd_q    <= '0;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_spi_done) begin
            rx_data_q  <= i_spi_data;
            rx_valid_q <= grant_q;
            cnt_q      <= cnt_q - LEN_ONE;
            if (cnt_q == LEN_ONE) begin
              done_q  <= grant_q;
              state_q <= ST_RELEASE;
            end else begin
              state_q <= ST_WAIT_TX;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
            if (wd_q == WD_LAST) begin
              err_q   <= grant_q;
              state_q <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          grant_q <= '0;
          ptr_q   <= (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_tx_ready           = (state_q == ST_WAIT_TX) ? grant_q : '0;
  assign o_grant              = grant_q;
  assign o_rx_data            = rx_data_q;
  assign o_rx_valid           = rx_valid_q;
  assign o_burst_done         = done_q;
  assign o_burst_error        = err_q;
  assign o_spi_enable         = en_q;
  assign o_spi_clock_polarity = cpol_q;
  assign o_spi_clock_phase    = cpha_q;
  assign o_spi_clock_divider  = div_q;
  assign o_spi_data           = spi_data_q;

endmodule

// File: tb/tb_spi_transfer_arbiter.sv
module tb_spi_transfer_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 5;
  localparam int LW = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [N-1:0]           req, cpol, cpha, txv;
  logic [N-1:0][LW-1:0]   rlen;
  logic [N-1:0][CW-1:0]   rdiv;
  logic [N-1:0][DW-1:0]   txd;
  logic [N-1:0]           tx_ready, grant, rx_valid, bdone, berr;
  logic [DW-1:0]          rx_data, spi_do, spi_di;
  logic                   spi_en, spi_cpol, spi_cpha, spi_done, spi_busy;
  logic [CW-1:0]          spi_div;

  spi_transfer_arbiter #(
    .NUM_REQUESTERS          (N),
    .SPI_DATA_WIDTH          (DW),
    .SPI_CLOCK_DIVIDER_WIDTH (CW),
    .LEN_WIDTH               (LW),
    .TIMEOUT_WIDTH           (TW)
  ) dut (
    .i_clock              (clk),
    .i_reset_n            (rst_n),
    .i_req                (req),
    .i_req_len            (rlen),
    .i_req_cpol           (cpol),
    .i_req_cpha           (cpha),
    .i_req_div            (rdiv),
    .i_tx_data            (txd),
    .i_tx_valid           (txv),
    .o_tx_ready           (tx_ready),
    .o_grant              (grant),
    .o_rx_data            (rx_data),
    .o_rx_valid           (rx_valid),
    .o_burst_done         (bdone),
    .o_burst_error        (berr),
    .o_spi_enable         (spi_en),
    .o_spi_clock_polarity (spi_cpol),
    .o_spi_clock_phase    (spi_cpha),
    .o_spi_clock_divider  (spi_div),
    .o_spi_data           (spi_do),
    .i_spi_data           (spi_di),
    .i_spi_done           (spi_done),
    .i_spi_busy           (spi_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int en_cnt = 0;
  int ptr_m = 0;
  int m_len [N];
  int m_cpol[N];
  int m_cpha[N];
  int m_div [N];
  logic [DW-1:0] rx_force[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (spi_en) en_cnt <= en_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (ptr_m + i) % N;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic setup_client(input int w, input int len, input int pol, input int pha, input int div);
    m_len[w]  = len;
    m_cpol[w] = pol;
    m_cpha[w] = pha;
    m_div[w]  = div;
    rlen[w]   = LW'(len);
    cpol[w]   = 1'(pol);
    cpha[w]   = 1'(pha);
    rdiv[w]   = CW'(div);
    req[w]    = 1'b1;
  endtask

  task automatic check_cfg(input int w);
    check_val("cfg_cpol", {31'd0, spi_cpol}, m_cpol[w]);
    check_val("cfg_cpha", {31'd0, spi_cpha}, m_cpha[w]);
    check_val("cfg_div", {27'd0, spi_div}, m_div[w]);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_grant"}, {28'd0, grant}, 0);
    check_val({tag, "_ready"}, {28'd0, tx_ready}, 0);
    check_val({tag, "_rxv"}, {28'd0, rx_valid}, 0);
    check_val({tag, "_done"}, {28'd0, bdone}, 0);
    check_val({tag, "_err"}, {28'd0, berr}, 0);
    check_val({tag, "_en"}, {31'd0, spi_en}, 0);
    check_val({tag, "_cpol"}, {31'd0, spi_cpol}, 0);
    check_val({tag, "_cpha"}, {31'd0, spi_cpha}, 0);
    check_val({tag, "_div"}, {27'd0, spi_div}, 32'h1F);
    check_val({tag, "_txdata"}, {24'd0, spi_do}, 0);
    check_val({tag, "_rxdata"}, {24'd0, rx_data}, 0);
  endtask

  // Serves one burst for client w: nserve words are exchanged; if fewer than
  // the burst length, the request is dropped in WAIT_TX (abort). tmo leaves
  // the first transfer without a done pulse.
  task automatic serve_burst(input int w, input int nserve, input bit drop, input bit tmo);
    int nwords, en0, c, t_g, t_e;
    bit ended;
    logic [DW-1:0] word, rx;
    nwords = (m_len[w] == 0) ? 1 : m_len[w];
    en0 = en_cnt;
    ended = 1'b0;
    c = 0;
    while (grant == '0 && c < 20) begin step(); c++; end
    check_val("grant", {28'd0, grant}, 1 << w);
    t_g = cyc;
    check_cfg(w);
    // Owner's inputs change mid-burst; they must be ignored.
    rlen[w] = LW'($urandom);
    cpol[w] = 1'($urandom);
    cpha[w] = 1'($urandom);
    rdiv[w] = CW'($urandom);
    for (int k = 0; k < nserve && !ended; k++) begin
      word = DW'($urandom);
      txd[w] = word;
      txv[w] = 1'b1;
      c = 0;
      while (!tx_ready[w] && c < 20) begin step(); c++; end
      check_val("tx_ready", {28'd0, tx_ready}, 1 << w);
      step();
      txv[w] = 1'b0;
      txd[w] = DW'($urandom);
      c = 0;
      while (!spi_en && c < 20) begin step(); c++; end
      check_val("enable", {31'd0, spi_en}, 1);
      if (k == 0) check_val("grant_to_enable", cyc - t_g, 3);
      check_val("spi_data", {24'd0, spi_do}, {24'd0, word});
      check_cfg(w);
      t_e = cyc;
      spi_busy = 1'b1;
      step();
      check_val("enable_pulse", {31'd0, spi_en}, 0);
      if (tmo) begin
        c = 0;
        while (berr == '0 && c < 40) begin step(); c++; end
        check_val("timeout_err", {28'd0, berr}, 1 << w);
        check_val("timeout_cycles", cyc - t_e, (1 << TW) - 1);
        spi_busy = 1'b0;
        ended = 1'b1;
      end else begin
        repeat ($urandom_range(0, 4)) step();
        rx = (rx_force.size() > 0) ? rx_force.pop_front() : DW'($urandom);
        spi_di = rx;
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        spi_busy = 1'b0;
        spi_di = DW'($urandom);
        check_val("rx_valid", {28'd0, rx_valid}, 1 << w);
        check_val("rx_data", {24'd0, rx_data}, {24'd0, rx});
        check_val("burst_done", {28'd0, bdone}, (k == nwords - 1) ? (1 << w) : 0);
        check_val("no_err", {28'd0, berr}, 0);
      end
    end
    if (!tmo && nserve < nwords) begin
      req[w] = 1'b0;
      step();
      check_val("abort_err", {28'd0, berr}, 1 << w);
      check_val("abort_done", {28'd0, bdone}, 0);
    end
    if (drop || tmo) req[w] = 1'b0;
    rlen[w] = LW'(m_len[w]);
    cpol[w] = 1'(m_cpol[w]);
    cpha[w] = 1'(m_cpha[w]);
    rdiv[w] = CW'(m_div[w]);
    step();
    check_val("release", {28'd0, grant}, 0);
    check_val("enable_count", en_cnt - en0, tmo ? 1 : nserve);
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    int w, c;
    rst_n = 1'b0;
    req = '0; cpol = '0; cpha = '0; txv = '0;
    rlen = '0; rdiv = '0; txd = '0;
    spi_di = '0; spi_done = 1'b0; spi_busy = 1'b0;
    repeat (3) step();
    check_reset("reset");
    rst_n = 1'b1;
    step();

    // Fairness: 0,2,3 continuous, single-word bursts.
    setup_client(0, 1, 0, 1, 3);
    setup_client(2, 1, 1, 1, 7);
    setup_client(3, 1, 0, 0, 2);
    for (int r = 0; r < 6; r++) begin
      w = pick(req);
      serve_burst(w, 1, (r >= 3), 1'b0);
    end

    // Pointer at 1 with 0 and 3 requesting: 3 wins.
    setup_client(0, 1, 1, 0, 9);
    serve_burst(pick(req), 1, 1'b1, 1'b0);
    setup_client(0, 2, 0, 1, 5);
    setup_client(3, 1, 1, 1, 6);
    w = pick(req);
    serve_burst(w, 1, 1'b1, 1'b0);
    w = pick(req);
    serve_burst(w, 2, 1'b1, 1'b0);

    // Single burst with fixed core data.
    rx_force.push_back(8'hA5);
    rx_force.push_back(8'h5A);
    rx_force.push_back(8'hFF);
    setup_client(1, 3, 1, 0, 4);
    serve_burst(pick(req), 3, 1'b1, 1'b0);

    // len 0 acts as a single word.
    setup_client(2, 0, 0, 1, 1);
    serve_burst(pick(req), 1, 1'b1, 1'b0);

    // Abort after one of four words.
    setup_client(0, 4, 1, 1, 12);
    serve_burst(pick(req), 1, 1'b1, 1'b0);

    // Watchdog timeout, then the waiting requester is served.
    setup_client(1, 2, 0, 0, 8);
    setup_client(2, 1, 1, 0, 30);
    w = pick(req);
    serve_burst(w, 1, 1'b1, 1'b1);
    w = pick(req);
    serve_burst(w, (m_len[w] == 0) ? 1 : m_len[w], 1'b1, 1'b0);

    // Reset during WAIT_DONE, then a stray done.
    setup_client(3, 2, 1, 1, 10);
    c = 0;
    while (grant == '0 && c < 20) begin step(); c++; end
    check_val("rst_grant", {28'd0, grant}, 1 << 3);
    txd[3] = 8'h3C;
    txv[3] = 1'b1;
    c = 0;
    while (!spi_en && c < 20) begin step(); c++; end
    check_val("rst_enable", {31'd0, spi_en}, 1);
    txv[3] = 1'b0;
    spi_busy = 1'b1;
    step();
    rst_n = 1'b0;
    req = '0;
    step();
    check_reset("midreset");
    rst_n = 1'b1;
    spi_busy = 1'b0;
    spi_di = 8'h77;
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    check_val("stray_rxv", {28'd0, rx_valid}, 0);
    check_val("stray_grant", {28'd0, grant}, 0);
    check_val("stray_rxdata", {24'd0, rx_data}, 0);
    ptr_m = 0;

    // Randomized rounds.
    for (int r = 0; r < 12; r++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (mask[i])
          setup_client(i, $urandom_range(0, 15), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 31));
      while (req != '0) begin
        w = pick(req);
        serve_burst(w, (m_len[w] == 0) ? 1 : m_len[w], 1'b1, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_transfer_arbiter.md
Name: spi_transfer_arbiter

Overview:
- Shares one spi_master core between NUM_REQUESTERS independent clients using round-robin arbitration.
- A granted client owns the SPI bus for a whole burst of 1..2^LEN_WIDTH-1 words. Its CPOL, CPHA and clock divider are latched at grant and driven to the core for the entire burst.
- Sits between client logic (drivers, register bridges) and spi_master, replacing direct spi_driver-to-core wiring.

Parameters:
- NUM_REQUESTERS, 4, number of clients (2..8).
- SPI_DATA_WIDTH, 8, word width; matches spi_master.
- SPI_CLOCK_DIVIDER_WIDTH, 5, divider width; matches spi_master.
- LEN_WIDTH, 4, burst-length field width.
- TIMEOUT_WIDTH, 16, watchdog counter width.

Ports:
- i_clock  in  1  system clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_req  in  NUM_REQUESTERS  per-client burst request (level).
- i_req_len  in  [NUM_REQUESTERS][LEN_WIDTH]  words in burst; 0 is treated as 1.
- i_req_cpol  in  NUM_REQUESTERS  per-client clock polarity.
- i_req_cpha  in  NUM_REQUESTERS  per-client clock phase.
- i_req_div  in  [NUM_REQUESTERS][SPI_CLOCK_DIVIDER_WIDTH]  per-client SPI clock divider.
- i_tx_data  in  [NUM_REQUESTERS][SPI_DATA_WIDTH]  per-client tx word.
- i_tx_valid  in  NUM_REQUESTERS  tx word valid.
- o_tx_ready  out  NUM_REQUESTERS  tx word accepted when ready&valid.
- o_grant  out  NUM_REQUESTERS  one-hot grant.
- o_rx_data  out  SPI_DATA_WIDTH  received word (shared bus).
- o_rx_valid  out  NUM_REQUESTERS  1-cycle pulse to the owner; qualifies o_rx_data.
- o_burst_done  out  NUM_REQUESTERS  1-cycle pulse after the last word completes.
- o_burst_error  out  NUM_REQUESTERS  1-cycle pulse on abort or timeout.
- o_spi_enable  out  1  start pulse to spi_master.
- o_spi_clock_polarity  out  1  to core.
- o_spi_clock_phase  out  1  to core.
- o_spi_clock_divider  out  SPI_CLOCK_DIVIDER_WIDTH  to core.
- o_spi_data  out  SPI_DATA_WIDTH  to core i_data_in.
- i_spi_data  in  SPI_DATA_WIDTH  from core o_data_out.
- i_spi_done  in  1  from core; 1-cycle pulse.
- i_spi_busy  in  1  from core.

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - state IDLE; RR pointer 0.
  - All grant, ready, valid, done, error and enable outputs 0.
  - cpol/cpha 0; divider all-ones (slowest); o_spi_data 0; o_rx_data 0.
- Reset mid-burst drops the grant the next cycle with no done or error pulse. The core must be reset alongside.
- All outputs are registered except o_tx_ready, which is combinational: o_tx_ready[g] = o_grant[g] && state==WAIT_TX.
- IDLE:
  - If any i_req is set, pick the first set bit at or after the pointer, wrapping around.
  - Next cycle: o_grant one-hot; cpol/cpha/div latched from the winner; word counter = len (0→1); go to SETTLE.
- SETTLE: wait until i_spi_busy==0 and at least one cycle has elapsed since config change, then go to WAIT_TX.
- WAIT_TX:
  - On i_tx_valid[g]: latch o_spi_data and go to START.
  - If i_req[g] falls before the handshake: pulse o_burst_error[g] and go to RELEASE.
- START: o_spi_enable=1 for exactly one cycle; clear the watchdog; go to WAIT_DONE.
- WAIT_DONE:
  - On i_spi_done: o_rx_data=i_spi_data, o_rx_valid[g]=1 the next cycle, decrement the counter.
    - Counter 1 → pulse o_burst_done[g] with the last rx_valid; go to RELEASE.
    - Otherwise go to WAIT_TX.
  - Watchdog increments each cycle. At all-ones: pulse o_burst_error[g] and go to RELEASE.
- RELEASE: o_grant=0; pointer=g+1 mod NUM_REQUESTERS; go to IDLE.
- Consequences:
  - Minimum one-cycle idle gap between grants.
  - Back-to-back requests from the same client lose priority to others.
- i_req, i_req_len and config changes during a burst are ignored, except the abort rule in WAIT_TX.
- i_spi_done outside WAIT_DONE is ignored.
- Latency:
  - i_req → o_grant: 1 cycle.
  - o_grant → earliest o_spi_enable: 3 cycles, given immediate valid.
  - i_spi_done → o_rx_valid: 1 cycle.

Decomposition:
- Package spi_pkg holds:
  - state enum typedef (IDLE, SETTLE, WAIT_TX, START, WAIT_DONE, RELEASE);
  - default divider constant.
- Sub-module spi_rr_arbiter: combinational round-robin pick from a request vector and a pointer. Outputs a one-hot winner and an index; it is reusable.

Test Plan:
- Single burst: client 1 requests len=3, cpol=1, cpha=0, div=4; model core returns A5,5A,FF → three o_rx_valid[1] pulses with those values, o_burst_done[1] with the third, o_grant[1] deasserts, core config stays 1/0/4 throughout.
- Fairness: clients 0, 2 and 3 request continuously, len=1 → grant order 0,2,3,0,2,3. Clients 0 and 3 then request together with pointer=1 → client 3 wins.
- len=0 from client 2 → exactly one o_spi_enable pulse and one rx, then done.
- Abort: client 0 requests len=4, supplies 1 word, then drops i_req in WAIT_TX → o_burst_error[0] pulse, 1 enable total, grant released.
- Timeout with TIMEOUT_WIDTH=4: core never pulses done → o_burst_error at 15 cycles after START; the next requester is then granted.
- Reset: assert i_reset_n=0 during WAIT_DONE → all outputs at reset values next cycle, divider=1F. A stray late i_spi_done is ignored.
